// File: rtl/mini_datapath_ctrl_if.sv
//==============================================================================
// Module   : mini_datapath_ctrl_if
// Brief    : Instruction valid/ready handshake bundle for mini_datapath_ctrl.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mini_datapath_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             instr_valid;
  logic             instr_ready;
  logic [WIDTH+7:0] instr;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );
endinterface

`default_nettype wire

// File: rtl/mini_datapath_ctrl.sv
//==============================================================================
// Module   : mini_datapath_ctrl
// Brief    : Three-cycle sequencer feeding mini_datapath from a 4-entry register
//            file. Optional macro CTRL_ZFLAG_EN adds a zero_flag output.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mini_datapath_ctrl #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  mini_datapath_ctrl_if.slave   instr_if,
  output logic [WIDTH-1:0]      dp_alu_in_a,
  output logic [WIDTH-1:0]      dp_reg_data,
  output logic [WIDTH-1:0]      dp_immediate_data,
  output logic [2:0]            dp_alu_sel,
  output logic                  dp_mux_sel,
  input  wire logic [WIDTH-1:0] dp_result,
  input  wire logic             dp_carry_out,
  output logic                  wb_valid,
  output logic [1:0]            wb_addr,
  output logic [WIDTH-1:0]      wb_data,
  output logic                  carry_flag
`ifdef CTRL_ZFLAG_EN
  ,
  output logic                  zero_flag
`endif
);

  localparam int IW = WIDTH + 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_rf [4];
  logic [1:0]       r_rd;

  logic [IW-1:0]    w_instr;
  logic [2:0]       w_op;
  logic             w_imm_f;
  logic [1:0]       w_rd;
  logic [1:0]       w_rs1;
  logic [WIDTH-1:0] w_field;
  logic             w_accept;

  assign w_instr  = instr_if.instr;
  assign w_op     = w_instr[IW-1 -: 3];
  assign w_imm_f  = w_instr[WIDTH+4];
  assign w_rd     = w_instr[WIDTH+3 -: 2];
  assign w_rs1    = w_instr[WIDTH+1 -: 2];
  assign w_field  = w_instr[WIDTH-1:0];

  assign instr_if.instr_ready = (r_state == S_IDLE);
  assign w_accept             = instr_if.instr_valid && instr_if.instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_WB;
      S_WB:    w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operands are captured at accept so the datapath sees a stable input set
  // for the whole EXEC cycle; a same-register write therefore cannot disturb them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_rf[i] <= '0;
      end
      r_rd              <= '0;
      dp_alu_in_a       <= '0;
      dp_reg_data       <= '0;
      dp_immediate_data <= '0;
      dp_alu_sel        <= '0;
      dp_mux_sel        <= 1'b0;
      wb_valid          <= 1'b0;
      wb_addr           <= '0;
      wb_data           <= '0;
      carry_flag        <= 1'b0;
`ifdef CTRL_ZFLAG_EN
      zero_flag         <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rd              <= w_rd;
            dp_alu_in_a       <= r_rf[w_rs1];
            dp_reg_data       <= r_rf[w_field[1:0]];
            dp_immediate_data <= w_field;
            dp_alu_sel        <= w_op;
            dp_mux_sel        <= w_imm_f;
          end
        end
        S_EXEC: begin
          r_rf[r_rd] <= dp_result;
          carry_flag <= dp_carry_out;
          wb_valid   <= 1'b1;
          wb_addr    <= r_rd;
          wb_data    <= dp_result;
`ifdef CTRL_ZFLAG_EN
          zero_flag  <= (dp_result == '0);
`endif
        end
        S_WB: begin
          wb_valid <= 1'b0;
        end
        default: begin
          wb_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mini_datapath_ctrl.sv
//==============================================================================
// Module   : tb_mini_datapath_ctrl
// Brief    : Scoreboard bench for mini_datapath_ctrl with a behavioural datapath.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mini_datapath_ctrl;

  localparam int WIDTH = 8;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    logic       c;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dp_alu_in_a, dp_reg_data, dp_immediate_data, dp_result, wb_data;
  logic [2:0] dp_alu_sel;
  logic       dp_mux_sel, dp_carry_out, wb_valid, carry_flag;
  logic [1:0] wb_addr;
`ifdef CTRL_ZFLAG_EN
  logic       zero_flag;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  mini_datapath_ctrl_if #(.WIDTH(WIDTH)) instr_if ();

  mini_datapath_ctrl #(.WIDTH(WIDTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .instr_if          (instr_if),
    .dp_alu_in_a       (dp_alu_in_a),
    .dp_reg_data       (dp_reg_data),
    .dp_immediate_data (dp_immediate_data),
    .dp_alu_sel        (dp_alu_sel),
    .dp_mux_sel        (dp_mux_sel),
    .dp_result         (dp_result),
    .dp_carry_out      (dp_carry_out),
    .wb_valid          (wb_valid),
    .wb_addr           (wb_addr),
    .wb_data           (wb_data),
    .carry_flag        (carry_flag)
`ifdef CTRL_ZFLAG_EN
    ,
    .zero_flag         (zero_flag)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in for mini_datapath: 000 ADD, 001 SUB, 010 AND, 011 OR, else XOR.
  logic [7:0] w_b;
  always_comb begin
    w_b          = dp_mux_sel ? dp_immediate_data : dp_reg_data;
    dp_result    = 8'h00;
    dp_carry_out = 1'b0;
    case (dp_alu_sel)
      3'b000:  {dp_carry_out, dp_result} = {1'b0, dp_alu_in_a} + {1'b0, w_b};
      3'b001:  {dp_carry_out, dp_result} = {1'b0, dp_alu_in_a} - {1'b0, w_b};
      3'b010:  dp_result = dp_alu_in_a & w_b;
      3'b011:  dp_result = dp_alu_in_a | w_b;
      default: dp_result = dp_alu_in_a ^ w_b;
    endcase
  end

  function automatic logic [15:0] mk(input logic [2:0] op, input logic imm,
                                     input logic [1:0] rd, input logic [1:0] rs1,
                                     input logic [7:0] field);
    return {op, imm, rd, rs1, field};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Present one instruction; expectation is queued only if the write should happen.
  task automatic send(input logic [15:0] w, input bit push, input logic [1:0] a,
                      input logic [7:0] d, input logic c);
    exp_t e;
    int   n;
    @(negedge clk);
    instr_if.instr_valid = 1'b1;
    instr_if.instr       = w;
    n = 0;
    while (!instr_if.instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!instr_if.instr_ready) begin
      chk("ready_timeout", 32'(instr_if.instr_ready), 32'd1);
    end else begin
      if (push) begin
        e.addr = a; e.data = d; e.c = c; e.z = (d == 8'h00);
        q.push_back(e);
      end
      @(posedge clk);
    end
    #1 instr_if.instr_valid = 1'b0;
  endtask

  // Monitor: every write-back pulse must match the oldest expectation.
  logic prev_wb = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && wb_valid) begin
        chk("wb_single_cycle", 32'(prev_wb), 32'd0);
        if (q.size() == 0) begin
          chk("wb_unexpected", 32'(wb_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("wb_addr", 32'(wb_addr), 32'(e.addr));
          chk("wb_data", 32'(wb_data), 32'(e.data));
          chk("carry_flag", 32'(carry_flag), 32'(e.c));
`ifdef CTRL_ZFLAG_EN
          chk("zero_flag", 32'(zero_flag), 32'(e.z));
`endif
        end
      end
      prev_wb = rst_n && wb_valid;
    end
  end

  initial begin
    int accepts;
    int n;
    instr_if.instr_valid = 1'b0;
    instr_if.instr       = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(instr_if.instr_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_carry", 32'(carry_flag), 32'd0);
    chk("rst_dp", {dp_alu_in_a, dp_reg_data, dp_immediate_data, 5'(dp_alu_sel), 3'(dp_mux_sel)}, 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of EXEC drops the instruction.
    send(mk(3'b000, 1'b1, 2'd1, 2'd0, 8'h0F), 1'b0, 2'd0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(instr_if.instr_ready), 32'd1);
    chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
    chk("midrst_dp_imm", 32'(dp_immediate_data), 32'd0);
    chk("midrst_dp_mux", 32'(dp_mux_sel), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // r1 must still be 0: r2 = r1 + r1
    send(mk(3'b000, 1'b0, 2'd2, 2'd1, 8'h01), 1'b1, 2'd2, 8'h00, 1'b0);
    send(mk(3'b000, 1'b1, 2'd1, 2'd0, 8'h0F), 1'b1, 2'd1, 8'h0F, 1'b0);
    send(mk(3'b000, 1'b1, 2'd2, 2'd0, 8'h03), 1'b1, 2'd2, 8'h03, 1'b0);
    send(mk(3'b000, 1'b0, 2'd3, 2'd1, 8'h02), 1'b1, 2'd3, 8'h12, 1'b0);
    send(mk(3'b010, 1'b0, 2'd3, 2'd1, 8'h02), 1'b1, 2'd3, 8'h03, 1'b0);
    send(mk(3'b011, 1'b1, 2'd3, 2'd1, 8'hF0), 1'b1, 2'd3, 8'hFF, 1'b0);
    // rd == rs1 == field register: r1 = r1 + r1
    send(mk(3'b000, 1'b0, 2'd1, 2'd1, 8'h01), 1'b1, 2'd1, 8'h1E, 1'b0);
    send(mk(3'b000, 1'b1, 2'd1, 2'd0, 8'hFF), 1'b1, 2'd1, 8'hFF, 1'b0);
    send(mk(3'b000, 1'b1, 2'd1, 2'd1, 8'h01), 1'b1, 2'd1, 8'h00, 1'b1);
    repeat (4) @(negedge clk);
    chk("carry_hold", 32'(carry_flag), 32'd1);
    chk("dp_hold_imm", 32'(dp_immediate_data), 32'h01);
    chk("dp_hold_sel", 32'(dp_alu_sel), 32'd0);
    chk("dp_hold_a", 32'(dp_alu_in_a), 32'hFF);
    send(mk(3'b000, 1'b1, 2'd2, 2'd2, 8'h05), 1'b1, 2'd2, 8'h08, 1'b0);
    // Reads observe the preceding write: r0 = r2 + r3 = 0x08 + 0xFF
    send(mk(3'b000, 1'b0, 2'd0, 2'd2, 8'h03), 1'b1, 2'd0, 8'h07, 1'b1);

    // Valid held continuously: accepts exactly every third cycle, r0 += 1 each.
    repeat (4) @(negedge clk);
    instr_if.instr       = mk(3'b000, 1'b1, 2'd0, 2'd0, 8'h01);
    instr_if.instr_valid = 1'b1;
    accepts = 0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      if (instr_if.instr_ready) begin
        chk("ready_phase", 32'(cyc % 3), 32'd0);
        accepts++;
        q.push_back('{addr: 2'd0, data: 8'(8'h07 + accepts), c: 1'b0, z: 1'b0});
      end else begin
        chk("no_ready_busy", 32'(cyc % 3 != 0), 32'd1);
      end
      @(negedge clk);
    end
    instr_if.instr_valid = 1'b0;
    chk("held_accepts", 32'(accepts), 32'd3);

    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
